pkt_buf_ctrl: RTL and testbench
===============================

Name: pkt_buf_ctrl

Overview:
- Ingress packet buffer and shared data memory that sits directly upstream of the two RISCV cores.
- Accepts 64-bit packet words from the network side and writes them into a 256x64 memory region.
- Publishes w_ptr, r_ptr, w_ptr_prev, p_en and count for the cores to poll.
- Serves each core's 1-cycle-latency load/store port and issues all_proc_done once both cores report completion through pi_di.

Parameters:
- BUF_BASE, 128: first memory address of the packet ring. Addresses below it are core scratch.
- BUF_DEPTH, 128: ring size in words. BUF_BASE+BUF_DEPTH must not exceed 256.
- MAX_WORDS, 64: maximum packet length in words. Longer packets are dropped.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_data  in  64  ingress packet word
- in_valid  in  1  ingress word valid
- in_sop  in  1  first word of packet
- in_eop  in  1  last word of packet
- in_ready  out  1  ingress may transfer (transfer = in_valid & in_ready)
- c0_addr_i  in  8  core0 memory address
- c0_din_i  in  64  core0 store data
- c0_wena_i  in  1  core0 store enable
- c0_dout_o  out  64  core0 load data, 1 cycle after address
- c1_addr_i, c1_din_i, c1_wena_i, c1_dout_o: same as core0, for core1
- pi_di0, pi_di1  in  1  per-core packet-processed flags (level)
- w_ptr  out  8  next ingress write address
- w_ptr_prev  out  8  start address of the current packet
- r_ptr  out  8  oldest unreleased address
- p_en  out  1  complete packet ready for processing
- count  out  8  word count of the current packet
- all_proc_done  out  1  single-cycle release pulse
- drop_cnt  out  8  dropped-packet counter, saturating

Behaviour:
- Reset (rst low, async) forces:
  - w_ptr = w_ptr_prev = r_ptr = BUF_BASE
  - count = 0, drop_cnt = 0
  - p_en = 0, all_proc_done = 0, in_ready = 0
  - c0_dout_o = c1_dout_o = 0
  - FSM = IDLE
  - Memory contents are not reset.
- Pointer wrap: an increment from BUF_BASE+BUF_DEPTH-1 returns to BUF_BASE. All pointer arithmetic is 8-bit.
- FSM states:
  - IDLE:
    - in_ready = 1.
    - A transfer with in_sop latches w_ptr_prev = w_ptr, writes the word, sets count = 1 and advances w_ptr.
    - If in_eop is also set, go to HOLD; otherwise go to RECV.
    - A transfer without in_sop is discarded and drop_cnt increments.
  - RECV:
    - in_ready = 1 except in a write-collision cycle.
    - Each transfer writes at w_ptr, then w_ptr++ and count++.
    - in_eop goes to HOLD.
    - A transfer that would make count exceed MAX_WORDS goes to DROP instead: w_ptr rewinds to w_ptr_prev, count = 0.
    - in_sop mid-packet counts as an error: the partial packet is discarded (rewind, drop_cnt++) and the new word is treated as an IDLE sop in the same cycle.
  - DROP:
    - in_ready = 1; words are consumed but not written.
    - in_eop returns to IDLE and drop_cnt increments.
  - HOLD:
    - p_en = 1, in_ready = 0.
    - When pi_di0 & pi_di1 is sampled high, all_proc_done pulses for exactly 1 cycle.
    - On that same edge: r_ptr = w_ptr, w_ptr_prev = w_ptr, count = 0, p_en = 0, go to IDLE.
    - The pulse is not repeated while pi_di stays high. The cores clear pi_di using all_proc_done.
- p_en and count are registered and change on the edge that enters or leaves HOLD.
- Memory:
  - One write port and two synchronous read ports.
  - Read data for address A presented in cycle N appears on cX_dout_o in cycle N+1. Read-during-write returns the old data.
- Write arbitration, per cycle:
  - Priority is c0 store, then c1 store, then ingress.
  - If any core store is active and ingress has in_valid, in_ready is driven 0 that cycle. in_ready is combinational from c0_wena_i | c1_wena_i.
  - Simultaneous c0 and c1 stores: c0 wins and c1's store is lost. Software must not issue these; the bench checks only the c0 result.
- Core stores to ring addresses are permitted and are not checked.
- Reset mid-packet discards all state. No partial pointer survives.
- drop_cnt saturates at 255.

Decomposition:
- Package pkt_buf_pkg holds:
  - FSM state encoding (IDLE, RECV, DROP, HOLD; 2 bits)
  - BUF_BASE/BUF_DEPTH defaults
  - the ring-increment function
- One sub-module, pkt_buf_mem: 256x64 memory with 1 write port and 2 registered read ports.

Test Plan:
- Reset, then a 4-word packet (sop at word 0, eop at word 3, data 0x11..0x44) → w_ptr_prev=128, w_ptr=132, count=4, p_en=1 the cycle after eop. c0 read of addr 130 returns 0x33 one cycle later.
- In HOLD, raise pi_di0 only → no pulse. Then raise pi_di1 → all_proc_done high for exactly 1 cycle, r_ptr=132, p_en=0, in_ready=1 next cycle.
- 3-word packet starting at w_ptr=254 (BUF_BASE=128, DEPTH=128) → words land at 254, 255, 128; w_ptr=129.
- 70-word packet (MAX_WORDS=64) → no p_en, w_ptr back to its start value, drop_cnt=1, FSM in IDLE after eop.
- Core0 store to addr 5 in the same cycle as in_valid → in_ready=0 that cycle, mem[5] updated, ingress word written the next cycle with no loss.
- Assert rst mid-RECV after 2 words → all pointers=128, count=0, p_en=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pkt_buf_pkg.sv
// Shared definitions for the ingress packet buffer.
//   state_e    : ingress FSM encoding (idle, receiving, dropping, holding for the cores)
//   Def*       : default ring placement and maximum packet length
//   ring_inc   : 8-bit pointer increment that wraps from the last ring slot back to the base
package pkt_buf_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRecv = 2'd1,
    StDrop = 2'd2,
    StHold = 2'd3
  } state_e;

  localparam int unsigned DefBufBase  = 128;
  localparam int unsigned DefBufDepth = 128;
  localparam int unsigned DefMaxWords = 64;

  // 'last' is the highest ring address; stepping past it lands on 'base'.
  function automatic logic [7:0] ring_inc(input logic [7:0] ptr,
                                          input logic [7:0] base,
                                          input logic [7:0] last);
    return (ptr == last) ? base : ptr + 8'd1;
  endfunction

endpackage

// File: rtl/pkt_buf_mem.sv
// 256x64 shared data memory: one write port, two synchronous read ports.
//   clk, rst        : clock, asynchronous active-low reset (read registers only)
//   we/waddr/wdata  : write port
//   raddr0/rdata0   : read port 0, data valid the cycle after the address
//   raddr1/rdata1   : read port 1, same timing
// A read of the address being written in the same cycle returns the old contents.
module pkt_buf_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [7:0]  waddr,
  input  logic [63:0] wdata,
  input  logic [7:0]  raddr0,
  output logic [63:0] rdata0,
  input  logic [7:0]  raddr1,
  output logic [63:0] rdata1
);

  logic [63:0] mem [256];

  // Array itself is never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      rdata0 <= mem[raddr0];
      rdata1 <= mem[raddr1];
    end
  end

endmodule

// File: rtl/pkt_buf_ctrl.sv
// Ingress packet buffer controller sitting upstream of two cores.
//   clk, rst                : clock, asynchronous active-low reset
//   in_data/valid/sop/eop   : ingress packet words; in_ready back-pressures ingress
//   c0_*/c1_*               : per-core load/store ports, 1-cycle read latency
//   pi_di0, pi_di1          : per-core "packet processed" levels
//   w_ptr, w_ptr_prev, r_ptr: next write address, current packet start, oldest unreleased
//   p_en, count             : a complete packet is held, and its length in words
//   all_proc_done           : one-cycle release pulse once both cores are done
//   drop_cnt                : saturating count of discarded packets / stray words
module pkt_buf_ctrl
  import pkt_buf_pkg::*;
#(
  parameter int unsigned BUF_BASE  = DefBufBase,
  parameter int unsigned BUF_DEPTH = DefBufDepth,
  parameter int unsigned MAX_WORDS = DefMaxWords
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  input  logic [7:0]  c0_addr_i,
  input  logic [63:0] c0_din_i,
  input  logic        c0_wena_i,
  output logic [63:0] c0_dout_o,
  input  logic [7:0]  c1_addr_i,
  input  logic [63:0] c1_din_i,
  input  logic        c1_wena_i,
  output logic [63:0] c1_dout_o,
  input  logic        pi_di0,
  input  logic        pi_di1,
  output logic [7:0]  w_ptr,
  output logic [7:0]  w_ptr_prev,
  output logic [7:0]  r_ptr,
  output logic        p_en,
  output logic [7:0]  count,
  output logic        all_proc_done,
  output logic [7:0]  drop_cnt
);

  localparam logic [7:0] Base     = 8'(BUF_BASE);
  localparam logic [7:0] Last     = 8'(BUF_BASE + BUF_DEPTH - 1);
  localparam logic [7:0] MaxWords = 8'(MAX_WORDS);

  state_e     state_q, state_d;
  logic [7:0] w_ptr_q, w_ptr_d;
  logic [7:0] w_ptr_prev_q, w_ptr_prev_d;
  logic [7:0] r_ptr_q, r_ptr_d;
  logic [7:0] count_q, count_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       p_en_q, p_en_d;
  logic       done_q, done_d;
  // Keeps in_ready low while reset is asserted and for the first cycle after release.
  logic       run_q;

  logic        core_wr;
  logic        xfer;
  logic        drop_inc;
  logic        ing_we;
  logic [7:0]  ing_addr;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [63:0] mem_wdata;

  assign core_wr = c0_wena_i | c1_wena_i;
  assign xfer    = in_valid & in_ready;

  // Ingress yields the single write port to any core store.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StIdle, StRecv: in_ready = run_q & ~(core_wr & in_valid);
      StDrop:         in_ready = run_q;
      StHold:         in_ready = 1'b0;
      default:        in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    w_ptr_d      = w_ptr_q;
    w_ptr_prev_d = w_ptr_prev_q;
    r_ptr_d      = r_ptr_q;
    count_d      = count_q;
    done_d       = 1'b0;
    drop_inc     = 1'b0;
    ing_we       = 1'b0;
    ing_addr     = w_ptr_q;

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          if (in_sop) begin
            w_ptr_prev_d = w_ptr_q;
            ing_we       = 1'b1;
            ing_addr     = w_ptr_q;
            count_d      = 8'd1;
            w_ptr_d      = ring_inc(w_ptr_q, Base, Last);
            state_d      = in_eop ? StHold : StRecv;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end

      StRecv: begin
        if (xfer) begin
          if (in_sop) begin
            // Abandon the partial packet and restart from its start address.
            drop_inc = 1'b1;
            ing_we   = 1'b1;
            ing_addr = w_ptr_prev_q;
            count_d  = 8'd1;
            w_ptr_d  = ring_inc(w_ptr_prev_q, Base, Last);
            state_d  = in_eop ? StHold : StRecv;
          end else if (count_q >= MaxWords) begin
            // Overlong packet: rewind and swallow the rest without writing.
            w_ptr_d = w_ptr_prev_q;
            count_d = 8'd0;
            if (in_eop) begin
              drop_inc = 1'b1;
              state_d  = StIdle;
            end else begin
              state_d = StDrop;
            end
          end else begin
            ing_we   = 1'b1;
            ing_addr = w_ptr_q;
            count_d  = count_q + 8'd1;
            w_ptr_d  = ring_inc(w_ptr_q, Base, Last);
            if (in_eop) begin
              state_d = StHold;
            end
          end
        end
      end

      StDrop: begin
        if (xfer && in_eop) begin
          drop_inc = 1'b1;
          state_d  = StIdle;
        end
      end

      StHold: begin
        if (pi_di0 && pi_di1) begin
          done_d       = 1'b1;
          r_ptr_d      = w_ptr_q;
          w_ptr_prev_d = w_ptr_q;
          count_d      = 8'd0;
          state_d      = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign p_en_d     = (state_d == StHold);
  assign drop_cnt_d = (drop_inc && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      w_ptr_q      <= Base;
      w_ptr_prev_q <= Base;
      r_ptr_q      <= Base;
      count_q      <= 8'd0;
      drop_cnt_q   <= 8'd0;
      p_en_q       <= 1'b0;
      done_q       <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_ptr_q      <= w_ptr_d;
      w_ptr_prev_q <= w_ptr_prev_d;
      r_ptr_q      <= r_ptr_d;
      count_q      <= count_d;
      drop_cnt_q   <= drop_cnt_d;
      p_en_q       <= p_en_d;
      done_q       <= done_d;
      run_q        <= 1'b1;
    end
  end

  // Write port priority: core0, then core1, then ingress.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ing_addr;
    mem_wdata = in_data;
    if (c0_wena_i) begin
      mem_we    = 1'b1;
      mem_waddr = c0_addr_i;
      mem_wdata = c0_din_i;
    end else if (c1_wena_i) begin
      mem_we    = 1'b1;
      mem_waddr = c1_addr_i;
      mem_wdata = c1_din_i;
    end else if (ing_we) begin
      mem_we    = 1'b1;
      mem_waddr = ing_addr;
      mem_wdata = in_data;
    end
  end

  pkt_buf_mem u_mem (
    .clk    (clk),
    .rst    (rst),
    .we     (mem_we),
    .waddr  (mem_waddr),
    .wdata  (mem_wdata),
    .raddr0 (c0_addr_i),
    .rdata0 (c0_dout_o),
    .raddr1 (c1_addr_i),
    .rdata1 (c1_dout_o)
  );

  assign w_ptr         = w_ptr_q;
  assign w_ptr_prev    = w_ptr_prev_q;
  assign r_ptr         = r_ptr_q;
  assign p_en          = p_en_q;
  assign count         = count_q;
  assign all_proc_done = done_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_pkt_buf_ctrl.sv
module tb_pkt_buf_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic        in_valid, in_sop, in_eop, in_ready;
  logic [7:0]  c0_addr_i, c1_addr_i;
  logic [63:0] c0_din_i, c1_din_i, c0_dout_o, c1_dout_o;
  logic        c0_wena_i, c1_wena_i;
  logic        pi_di0, pi_di1;
  logic [7:0]  w_ptr, w_ptr_prev, r_ptr, count, drop_cnt;
  logic        p_en, all_proc_done;

  int n_assert = 0;
  int n_fail   = 0;

  pkt_buf_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_ready      (in_ready),
    .c0_addr_i     (c0_addr_i),
    .c0_din_i      (c0_din_i),
    .c0_wena_i     (c0_wena_i),
    .c0_dout_o     (c0_dout_o),
    .c1_addr_i     (c1_addr_i),
    .c1_din_i      (c1_din_i),
    .c1_wena_i     (c1_wena_i),
    .c1_dout_o     (c1_dout_o),
    .pi_di0        (pi_di0),
    .pi_di1        (pi_di1),
    .w_ptr         (w_ptr),
    .w_ptr_prev    (w_ptr_prev),
    .r_ptr         (r_ptr),
    .p_en          (p_en),
    .count         (count),
    .all_proc_done (all_proc_done),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_pkt(input int len, input logic [63:0] base);
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_sop   = (i == 0);
      in_eop   = (i == len - 1);
      in_data  = base + 64'(i);
      tick();
    end
    idle_in();
  endtask

  task automatic release_pkt(input string tag);
    pi_di0 = 1'b1;
    pi_di1 = 1'b1;
    tick();
    chk({tag, "_done_hi"}, 64'(all_proc_done), 64'd1);
    pi_di0 = 1'b0;
    pi_di1 = 1'b0;
    tick();
    chk({tag, "_done_lo"}, 64'(all_proc_done), 64'd0);
  endtask

  initial begin
    rst       = 1'b0;
    idle_in();
    c0_addr_i = '0;
    c1_addr_i = '0;
    c0_din_i  = '0;
    c1_din_i  = '0;
    c0_wena_i = 1'b0;
    c1_wena_i = 1'b0;
    pi_di0    = 1'b0;
    pi_di1    = 1'b0;

    // Reset state
    tick();
    chk("rst_w_ptr", 64'(w_ptr), 64'd128);
    chk("rst_w_ptr_prev", 64'(w_ptr_prev), 64'd128);
    chk("rst_r_ptr", 64'(r_ptr), 64'd128);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_p_en", 64'(p_en), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_c0_dout", c0_dout_o, 64'd0);
    chk("rst_c1_dout", c1_dout_o, 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst = 1'b1;
    tick();
    tick();
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // 4-word packet 0x11..0x44
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sop   = (i == 0);
      in_eop   = (i == 3);
      in_data  = 64'h11 * 64'(i + 1);
      tick();
    end
    idle_in();
    chk("p4_w_ptr_prev", 64'(w_ptr_prev), 64'd128);
    chk("p4_w_ptr", 64'(w_ptr), 64'd132);
    chk("p4_count", 64'(count), 64'd4);
    chk("p4_p_en", 64'(p_en), 64'd1);
    chk("p4_hold_ready", 64'(in_ready), 64'd0);
    c0_addr_i = 8'd130;
    tick();
    chk("p4_rd130", c0_dout_o, 64'h33);

    // Only one core done: no release
    pi_di0 = 1'b1;
    tick();
    chk("half_done", 64'(all_proc_done), 64'd0);
    chk("half_p_en", 64'(p_en), 64'd1);
    pi_di1 = 1'b1;
    tick();
    chk("rel_done", 64'(all_proc_done), 64'd1);
    chk("rel_r_ptr", 64'(r_ptr), 64'd132);
    chk("rel_p_en", 64'(p_en), 64'd0);
    chk("rel_count", 64'(count), 64'd0);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    pi_di0 = 1'b0;
    pi_di1 = 1'b0;
    tick();
    chk("rel_pulse_once", 64'(all_proc_done), 64'd0);

    // Overlong packet is dropped and the pointer rewinds
    send_pkt(70, 64'h1000);
    chk("long_p_en", 64'(p_en), 64'd0);
    chk("long_w_ptr", 64'(w_ptr), 64'd132);
    chk("long_count", 64'(count), 64'd0);
    chk("long_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("long_idle_ready", 64'(in_ready), 64'd1);

    // Fill up to 254 with two 61-word packets
    send_pkt(61, 64'h2000);
    chk("f1_count", 64'(count), 64'd61);
    chk("f1_w_ptr", 64'(w_ptr), 64'd193);
    release_pkt("f1");
    send_pkt(61, 64'h3000);
    chk("f2_w_ptr", 64'(w_ptr), 64'd254);
    release_pkt("f2");
    chk("f2_r_ptr", 64'(r_ptr), 64'd254);

    // Wrapping 3-word packet: 254, 255, 128
    send_pkt(3, 64'hA1);
    chk("wrap_w_ptr", 64'(w_ptr), 64'd129);
    chk("wrap_w_ptr_prev", 64'(w_ptr_prev), 64'd254);
    chk("wrap_count", 64'(count), 64'd3);
    c0_addr_i = 8'd254;
    c1_addr_i = 8'd255;
    tick();
    chk("wrap_rd254", c0_dout_o, 64'hA1);
    chk("wrap_rd255", c1_dout_o, 64'hA2);
    c0_addr_i = 8'd128;
    tick();
    chk("wrap_rd128", c0_dout_o, 64'hA3);
    release_pkt("wrap");

    // Core store collides with ingress sop
    c0_wena_i = 1'b1;
    c0_addr_i = 8'd5;
    c0_din_i  = 64'hDEAD;
    in_valid  = 1'b1;
    in_sop    = 1'b1;
    in_data   = 64'hB1;
    #1;
    chk("col_ready_lo", 64'(in_ready), 64'd0);
    tick();
    c0_wena_i = 1'b0;
    #1;
    chk("col_ready_hi", 64'(in_ready), 64'd1);
    chk("col_no_xfer", 64'(w_ptr), 64'd129);
    tick();
    in_sop  = 1'b0;
    in_eop  = 1'b1;
    in_data = 64'hB2;
    tick();
    idle_in();
    chk("col_w_ptr", 64'(w_ptr), 64'd131);
    chk("col_count", 64'(count), 64'd2);
    c0_addr_i = 8'd5;
    c1_addr_i = 8'd129;
    tick();
    chk("col_rd5", c0_dout_o, 64'hDEAD);
    chk("col_rd129", c1_dout_o, 64'hB1);
    release_pkt("col");

    // Stray word without sop in idle is counted as a drop
    in_valid = 1'b1;
    in_data  = 64'hEE;
    tick();
    idle_in();
    chk("stray_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("stray_w_ptr", 64'(w_ptr), 64'd131);

    // Asynchronous reset in the middle of a packet
    in_valid = 1'b1;
    in_sop   = 1'b1;
    in_data  = 64'hC1;
    tick();
    in_sop  = 1'b0;
    in_data = 64'hC2;
    tick();
    idle_in();
    chk("mid_w_ptr", 64'(w_ptr), 64'd133);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_w_ptr", 64'(w_ptr), 64'd128);
    chk("arst_w_ptr_prev", 64'(w_ptr_prev), 64'd128);
    chk("arst_r_ptr", 64'(r_ptr), 64'd128);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_p_en", 64'(p_en), 64'd0);
    chk("arst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_c1_dout", c1_dout_o, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
